// File: rtl/alu_pkg.sv
// alu_pkg: shared width and opcode encodings for the ice-risc ALU
package alu_pkg;
  localparam int XLEN = 32;
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_AND  = 6'd2;
  localparam logic [5:0] ALU_OR   = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_NOR  = 6'd5;
  localparam logic [5:0] ALU_SLL  = 6'd6;
  localparam logic [5:0] ALU_SRL  = 6'd7;
  localparam logic [5:0] ALU_SRA  = 6'd8;
  localparam logic [5:0] ALU_SLT  = 6'd9;
  localparam logic [5:0] ALU_SLTU = 6'd10;
  localparam logic [5:0] ALU_MUL  = 6'd11;
  localparam logic [5:0] ALU_PASSA = 6'd12;
  localparam logic [5:0] ALU_PASSB = 6'd13;
  localparam logic [5:0] ALU_LUI  = 6'd14;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational operation select, unused opcodes yield zero
module alu_core
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [5:0]      op_i,
  output logic [XLEN-1:0] res_o
);
  logic [4:0] sh;
  assign sh = b_i[4:0];
  // result mux; only the low five bits of b shift
  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_ADD:   res_o = a_i + b_i;
      ALU_SUB:   res_o = a_i - b_i;
      ALU_AND:   res_o = a_i & b_i;
      ALU_OR:    res_o = a_i | b_i;
      ALU_XOR:   res_o = a_i ^ b_i;
      ALU_NOR:   res_o = ~(a_i | b_i);
      ALU_SLL:   res_o = a_i << sh;
      ALU_SRL:   res_o = a_i >> sh;
      ALU_SRA:   res_o = $unsigned($signed(a_i) >>> sh);
      ALU_SLT:   res_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  res_o = {31'b0, a_i < b_i};
      ALU_MUL:   res_o = a_i * b_i;
      ALU_PASSA: res_o = a_i;
      ALU_PASSB: res_o = b_i;
      ALU_LUI:   res_o = {b_i[15:0], 16'h0};
      default:   res_o = '0;
    endcase
  end
endmodule

// File: rtl/alu.sv
// alu: registered 32-bit ALU with zero/sign flags derived from the same next result
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [5:0]      op,
  output logic            zero,
  output logic            sign,
  output logic [XLEN-1:0] x
);
  logic [XLEN-1:0] x_d, x_q;
  logic            zero_q, sign_q;
  alu_core u_core (.a_i(a), .b_i(b), .op_i(op), .res_o(x_d));
  // result and flags update together so they never disagree
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      zero_q <= 1'b1;
      sign_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      zero_q <= x_d == '0;
      sign_q <= x_d[XLEN-1];
    end
  end
  assign x    = x_q;
  assign zero = zero_q;
  assign sign = sign_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized scoreboard bench for the registered ALU
module tb_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0, b = '0, x;
  logic [5:0]  op = '0;
  logic        zero, sign;
  int          passed = 0, total = 0;
  typedef struct packed {
    logic [31:0] x;
    logic        z;
    logic        s;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  alu dut (.clk(clk), .rst(rst), .a(a), .b(b), .op(op), .zero(zero), .sign(sign), .x(x));
  function automatic logic [31:0] model(input logic [5:0] o, input logic [31:0] aa, input logic [31:0] bb);
    int unsigned sh;
    longint unsigned p;
    sh = int'(bb[4:0]);
    p  = longint'(aa) * longint'(bb);
    case (int'(o))
      0:  return aa + bb;
      1:  return aa + ~bb + 32'd1;
      2:  return aa & bb;
      3:  return aa | bb;
      4:  return aa ^ bb;
      5:  return ~(aa | bb);
      6:  return aa << sh;
      7:  return aa >> sh;
      8:  return aa[31] ? ~((~aa) >> sh) : aa >> sh;
      9:  return (int'(aa) < int'(bb)) ? 32'd1 : 32'd0;
      10: return (aa < bb) ? 32'd1 : 32'd0;
      11: return p[31:0];
      12: return aa;
      13: return bb;
      14: return bb * 32'h10000;
      default: return 32'd0;
    endcase
  endfunction
  function automatic exp_t mk(input logic [31:0] v);
    mk.x = v;
    mk.z = (v == 32'd0);
    mk.s = v[31];
  endfunction
  task automatic issue(input bit r, input logic [5:0] o, input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    rst = r;
    op  = o;
    a   = aa;
    b   = bb;
    q.push_back(r ? mk(32'd0) : mk(model(o, aa, bb)));
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s op=%0d a=%h b=%h rst=%0b: got %h expected %h", name, op, a, b, rst, got, want);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("x", x, e.x);
        chk("zero", {31'b0, zero}, {31'b0, e.z});
        chk("sign", {31'b0, sign}, {31'b0, e.s});
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) issue(1'b1, 6'($urandom), $urandom, $urandom);
    issue(1'b0, 6'd0, 32'd1234, 32'd5678);
    issue(1'b0, 6'd1, 32'd1234, 32'd5678);
    issue(1'b0, 6'd1, 32'd1234, 32'd1234);
    issue(1'b0, 6'd6, 32'd1234, 32'd3);
    issue(1'b0, 6'd7, 32'h82345671, 32'd3);
    issue(1'b0, 6'd8, 32'h82345671, 32'd3);
    issue(1'b0, 6'd9, 32'h82345671, 32'h82345555);
    issue(1'b0, 6'd10, 32'h82345671, 32'h82345555);
    issue(1'b0, 6'd9, 32'h82345671, 32'h83455555);
    issue(1'b0, 6'd10, 32'h82345671, 32'h83455555);
    issue(1'b0, 6'd8, 32'h7FFFFFFF, 32'hFFFFFFFF);
    issue(1'b0, 6'd14, 32'd0, 32'hABCD1234);
    for (int i = 0; i < 300; i++)
      issue(($urandom_range(0, 19) == 0), 6'($urandom_range(0, 15)), $urandom, $urandom);
    for (int i = 0; i < 64; i++)
      issue(i == 30 || i == 31, 6'(i), 32'h82345671, 32'h00000003);
    issue(1'b0, 6'd12, 32'h80000000, 32'd0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
